// File: rtl/ysyx_25040109_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply, restoring divide.
// Latency 33 cycles accept->out_valid (1 for div-by-zero/overflow); result held in DONE until out_ready.
module ysyx_25040109_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]      op;
  logic            neg_res;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [CW-1:0]   cnt;

  logic            sgn1, sgn2, neg1, neg2;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag1, mag2, special_val;

  // Operands are reduced to magnitudes up front; the sign is reapplied once at the end.
  always_comb begin
    sgn1     = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn2     = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg1     = sgn1 && src1[XLEN-1];
    neg2     = sgn2 && src2[XLEN-1];
    mag1     = neg1 ? -src1 : src1;
    mag2     = neg2 ? -src2 : src2;
    div_zero = funct3[2] && (src2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_val = funct3[1] ? src1 : '1;
    else          special_val = funct3[1] ? '0 : src1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    case (state)
      IDLE: if (in_valid && !flush) begin
        accept    = 1'b1;
        state_nxt = special ? DONE : BUSY;
      end
      BUSY: begin
        if (flush)             state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = DONE;
      end
      DONE: if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n, div_val, fin;
  logic [2*XLEN-1:0] prod, prod_s;

  // acc_hi:acc_lo is the partial product (multiply) or remainder:quotient (divide).
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted - {1'b0, opb};
    if (op[2]) begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {acc_lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], acc_lo[XLEN-1:1]};
    end
    prod    = {hi_n, lo_n};
    prod_s  = neg_res ? -prod : prod;
    div_val = op[1] ? hi_n : lo_n;
    if (op[2])              fin = neg_res ? -div_val : div_val;
    else if (op[1:0] == 2'b00) fin = prod_s[XLEN-1:0];
    else                    fin = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      neg_res <= 1'b0;
      opb     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else if (accept) begin
      op      <= funct3;
      rd_out  <= rd_in;
      cnt     <= '0;
      acc_hi  <= '0;
      neg_res <= (funct3[2] && funct3[1]) ? neg1 : (neg1 ^ neg2);
      opb     <= funct3[2] ? mag2 : mag1;
      acc_lo  <= funct3[2] ? mag1 : mag2;
      if (special) result <= special_val;
    end else if (state == BUSY) begin
      if (flush) begin
        cnt <= '0;
      end else begin
        acc_hi <= hi_n;
        acc_lo <= lo_n;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) result <= fin;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_mdu.sv
// Directed bench for the MDU: arithmetic reference model, scoreboard compare at negedge,
// plus latency, backpressure, flush and reset scenarios.
module tb_ysyx_25040109_mdu;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] src1, src2, result;
  logic [4:0]  rd_in, rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  ysyx_25040109_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .src1(src1), .src2(src2), .rd_in(rd_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Scoreboard: every visible result must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got result %h rd %0d with no request outstanding", result, rd_out);
      end else begin
        check("sb_result", result, expq[0].res);
        check("sb_rd_out", {27'b0, rd_out}, {27'b0, expq[0].rd});
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin cyc(); n++; end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int exp_lat,
                       input int hold, input bit has_lit, input logic [31:0] lit);
    int          n;
    logic [31:0] e;
    e = model(f, a, b);
    out_ready = (hold == 0);
    wait_ready();
    funct3 = f; src1 = a; src2 = b; rd_in = rd; in_valid = 1'b1;
    expq.push_back('{res: e, rd: rd});
    cyc();
    in_valid = 1'b0;
    funct3 = 3'($urandom); src1 = $urandom; src2 = $urandom; rd_in = 5'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin cyc(); n++; end
    check({name, "_latency"}, 32'(n + 1), 32'(exp_lat));
    if (has_lit) begin
      check({name, "_literal"}, result, lit);
      check({name, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
    end
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({name, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      check({name, "_hold_result"}, result, e);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    check({name, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    check({name, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid) seen++;
      cyc();
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    funct3 = 3'd0; src1 = '0; src2 = '0; rd_in = '0;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'b0, rd_out}, 32'd0);

    check("model_mul", model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("model_mulhu", model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("model_div", model(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("model_rem", model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);

    do_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  33, 0, 1'b1, 32'hFFFFFFEB);
    do_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  33, 0, 1'b1, 32'hFFFFFFFE);
    do_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  33, 0, 1'b1, 32'h00000000);
    do_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  33, 0, 1'b1, 32'hFFFFFFFF);
    do_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd4,  33, 0, 1'b1, 32'hFFFFFFFD);
    do_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  33, 0, 1'b1, 32'hFFFFFFFF);
    do_op("divu",   3'd5, 32'd100,      32'd7,        5'd7,  33, 0, 1'b1, 32'd14);
    do_op("remu",   3'd7, 32'd100,      32'd7,        5'd8,  33, 0, 1'b1, 32'd2);
    do_op("div_nn", 3'd4, 32'h80000001, 32'hFFFFFFFD, 5'd9,  33, 0, 1'b0, 32'd0);
    do_op("rem_pn", 3'd6, 32'd1000,     32'hFFFFFFF9, 5'd10, 33, 0, 1'b0, 32'd0);
    do_op("mulh_b", 3'd1, 32'h80000000, 32'h80000000, 5'd11, 33, 0, 1'b0, 32'd0);
    do_op("mul_b",  3'd0, 32'h12345678, 32'h9ABCDEF0, 5'd12, 33, 0, 1'b0, 32'd0);

    do_op("divu_z", 3'd5, 32'd1234,     32'd0,        5'd13, 1, 0, 1'b1, 32'hFFFFFFFF);
    do_op("remu_z", 3'd7, 32'd1234,     32'd0,        5'd14, 1, 0, 1'b1, 32'd1234);
    do_op("div_z",  3'd4, 32'hFFFFFF00, 32'd0,        5'd15, 1, 0, 1'b1, 32'hFFFFFFFF);
    do_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 1, 0, 1'b1, 32'd0);
    do_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd17, 1, 0, 1'b1, 32'h80000000);

    do_op("bp_div", 3'd4, 32'd12345,    32'hFFFFFFFB, 5'd18, 33, 10, 1'b0, 32'd0);
    do_op("bp_spc", 3'd5, 32'd5,        32'd0,        5'd19, 1,  10, 1'b1, 32'hFFFFFFFF);

    wait_ready();
    funct3 = 3'd0; src1 = 32'd3; src2 = 32'd4; rd_in = 5'd20; in_valid = 1'b1; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", {31'b0, busy}, 32'd0);
    check("idle_flush_in_ready", {31'b0, in_ready}, 32'd1);

    funct3 = 3'd0; src1 = 32'd9; src2 = 32'd9; rd_in = 5'd21; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (11) cyc();
    check("flush_busy_mid", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_busy", {31'b0, busy}, 32'd0);
    watch_quiet("flush_no_output", 40);

    funct3 = 3'd4; src1 = 32'd77; src2 = 32'd5; rd_in = 5'd22; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    watch_quiet("rst_no_output", 40);

    do_op("post",   3'd3, 32'hDEADBEEF, 32'hCAFEF00D, 5'd23, 33, 0, 1'b0, 32'd0);
    repeat (2) cyc();
    check("sb_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
